// File: rtl/proc_pkg.sv
// Shared processor constants: default register-bank geometry and the write-counter ceiling.
package proc_pkg;

  localparam int DEFAULT_DATA_W   = 8;
  localparam int DEFAULT_NUM_REGS = 4;
  localparam int WR_COUNT_W       = 8;

  localparam logic [WR_COUNT_W-1:0] WR_COUNT_MAX = 8'd255;

  // The counter holds at its ceiling instead of wrapping back to zero.
  function automatic logic [WR_COUNT_W-1:0] sat_inc(input logic [WR_COUNT_W-1:0] value);
    return (value == WR_COUNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/reg_bank_sel.sv
// Small register bank with selectable write source, a 1-cycle registered read port and a read-only external slot.
// Optional macro REG_BANK_BYPASS_EN forwards same-cycle write data to a read of the same index.
module reg_bank_sel
  import proc_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_W-1:0]     in,
  input  logic [DATA_W-1:0]     barramento_mem,
  input  logic                  src_mem,
  input  logic                  wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_sel,
  input  logic                  rd_req,
  input  logic [$clog2(NUM_REGS)-1:0] rd_sel,
  input  logic [DATA_W-1:0]     ext_in,
  output logic [DATA_W-1:0]     choice_out,
  output logic                  choice_valid,
  output logic [DATA_W-1:0]     led_output,
  output logic [NUM_REGS-1:0]   dirty,
  output logic [WR_COUNT_W-1:0] wr_count
);

  localparam int SEL_W = $clog2(NUM_REGS);
  localparam logic [SEL_W-1:0] EXT_IDX = SEL_W'(NUM_REGS - 1);

  // The top entry is never written; reads of that index come from ext_in instead.
  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [DATA_W-1:0]   wr_data;
  logic                wr_accept;
  logic [DATA_W-1:0]   rd_data;
  logic [NUM_REGS-1:0] dirty_next;

  assign wr_data   = src_mem ? barramento_mem : in;
  assign wr_accept = wr_en && (wr_sel != EXT_IDX);

  always_comb begin
    rd_data = (rd_sel == EXT_IDX) ? ext_in : regs[rd_sel];
`ifdef REG_BANK_BYPASS_EN
    if (wr_accept && (wr_sel == rd_sel)) begin
      rd_data = wr_data;
    end
`endif
  end

  // Set wins over clear so a write racing a read of the same slot stays flagged.
  always_comb begin
    dirty_next = dirty;
    if (rd_req) begin
      dirty_next[rd_sel] = 1'b0;
    end
    if (wr_accept) begin
      dirty_next[wr_sel] = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      choice_out   <= '0;
      choice_valid <= 1'b0;
      led_output   <= '0;
      dirty        <= '0;
      wr_count     <= '0;
    end else begin
      if (wr_accept) begin
        regs[wr_sel] <= wr_data;
        wr_count     <= sat_inc(wr_count);
      end
      if (rd_req) begin
        choice_out <= rd_data;
      end
      choice_valid <= rd_req;
      led_output   <= in;
      dirty        <= dirty_next;
    end
  end

endmodule

// File: tb/tb_reg_bank_sel.sv
// Directed self-checking bench for reg_bank_sel; expectations follow REG_BANK_BYPASS_EN when it is defined.
module tb_reg_bank_sel;

  localparam int DATA_W   = 8;
  localparam int NUM_REGS = 4;

  logic              clock;
  logic              reset_n;
  logic [DATA_W-1:0] in;
  logic [DATA_W-1:0] barramento_mem;
  logic              src_mem;
  logic              wr_en;
  logic [1:0]        wr_sel;
  logic              rd_req;
  logic [1:0]        rd_sel;
  logic [DATA_W-1:0] ext_in;
  logic [DATA_W-1:0] choice_out;
  logic              choice_valid;
  logic [DATA_W-1:0] led_output;
  logic [NUM_REGS-1:0] dirty;
  logic [7:0]        wr_count;

  int checks = 0;
  int errors = 0;

  reg_bank_sel #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in            (in),
    .barramento_mem(barramento_mem),
    .src_mem       (src_mem),
    .wr_en         (wr_en),
    .wr_sel        (wr_sel),
    .rd_req        (rd_req),
    .rd_sel        (rd_sel),
    .ext_in        (ext_in),
    .choice_out    (choice_out),
    .choice_valid  (choice_valid),
    .led_output    (led_output),
    .dirty         (dirty),
    .wr_count      (wr_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change 1 time unit after the rising edge, so outputs are sampled there too.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [DATA_W-1:0] same_cycle_exp;
`ifdef REG_BANK_BYPASS_EN
    same_cycle_exp = 8'h22;
`else
    same_cycle_exp = 8'h10;
`endif
    reset_n = 1'b0;
    in = 8'h00; barramento_mem = 8'h00; src_mem = 1'b0; wr_en = 1'b0;
    wr_sel = 2'd0; rd_req = 1'b0; rd_sel = 2'd0; ext_in = 8'h00;

    #12;
    check("rst_choice_out", 32'(choice_out), 32'h0);
    check("rst_choice_valid", 32'(choice_valid), 32'h0);
    check("rst_led", 32'(led_output), 32'h0);
    check("rst_dirty", 32'(dirty), 32'h0);
    check("rst_wr_count", 32'(wr_count), 32'h0);
    tick();
    reset_n = 1'b1;
    tick();

    in = 8'h5A; src_mem = 1'b0; wr_en = 1'b1; wr_sel = 2'd0;
    tick();
    check("w0_dirty", 32'(dirty), 32'b0001);
    check("w0_wr_count", 32'(wr_count), 32'd1);
    check("w0_led", 32'(led_output), 32'h5A);
    wr_en = 1'b0; rd_req = 1'b1; rd_sel = 2'd0;
    tick();
    check("r0_data", 32'(choice_out), 32'h5A);
    check("r0_valid", 32'(choice_valid), 32'h1);
    check("r0_dirty", 32'(dirty), 32'b0000);
    rd_req = 1'b0;
    tick();
    check("r0_valid_drop", 32'(choice_valid), 32'h0);
    check("r0_hold", 32'(choice_out), 32'h5A);

    src_mem = 1'b1; barramento_mem = 8'hC3; in = 8'h11; wr_en = 1'b1; wr_sel = 2'd1;
    tick();
    wr_en = 1'b0; rd_req = 1'b1; rd_sel = 2'd1;
    tick();
    check("r1_mem_src", 32'(choice_out), 32'hC3);
    check("r1_valid", 32'(choice_valid), 32'h1);
    check("r1_led", 32'(led_output), 32'h11);
    check("r1_wr_count", 32'(wr_count), 32'd2);
    rd_req = 1'b0;

    ext_in = 8'h7E; src_mem = 1'b0; in = 8'hFF; wr_en = 1'b1; wr_sel = 2'd3;
    tick();
    check("ext_wr_count", 32'(wr_count), 32'd2);
    check("ext_dirty", 32'(dirty), 32'b0000);
    wr_en = 1'b0; rd_req = 1'b1; rd_sel = 2'd3;
    tick();
    check("r3_ext", 32'(choice_out), 32'h7E);
    rd_req = 1'b0;

    in = 8'h10; wr_en = 1'b1; wr_sel = 2'd2;
    tick();
    in = 8'h22; wr_en = 1'b1; wr_sel = 2'd2; rd_req = 1'b1; rd_sel = 2'd2;
    tick();
    check("same_cycle_data", 32'(choice_out), 32'(same_cycle_exp));
    check("same_cycle_dirty2", 32'(dirty[2]), 32'h1);
    check("same_cycle_wr_count", 32'(wr_count), 32'd4);
    wr_en = 1'b0; rd_req = 1'b1; rd_sel = 2'd2;
    tick();
    check("r2_after", 32'(choice_out), 32'h22);
    check("r2_dirty_clear", 32'(dirty[2]), 32'h0);

    rd_sel = 2'd0;
    tick();
    check("b2b_0_data", 32'(choice_out), 32'h5A);
    check("b2b_0_valid", 32'(choice_valid), 32'h1);
    rd_sel = 2'd1;
    tick();
    check("b2b_1_data", 32'(choice_out), 32'hC3);
    check("b2b_1_valid", 32'(choice_valid), 32'h1);
    rd_req = 1'b0;
    tick();
    check("b2b_end_valid", 32'(choice_valid), 32'h0);

    wr_en = 1'b1; wr_sel = 2'd0;
    for (int i = 0; i < 300; i++) begin
      in = 8'(i);
      tick();
    end
    check("sat_wr_count", 32'(wr_count), 32'd255);
    check("sat_dirty0", 32'(dirty[0]), 32'h1);
    wr_en = 1'b0;

    rd_req = 1'b1; rd_sel = 2'd0;
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("midrst_choice_out", 32'(choice_out), 32'h0);
    check("midrst_valid", 32'(choice_valid), 32'h0);
    check("midrst_led", 32'(led_output), 32'h0);
    check("midrst_dirty", 32'(dirty), 32'h0);
    check("midrst_wr_count", 32'(wr_count), 32'h0);
    tick();
    check("midrst_valid_held", 32'(choice_valid), 32'h0);
    rd_req = 1'b0;
    reset_n = 1'b1;
    tick();
    check("post_rst_valid", 32'(choice_valid), 32'h0);
    rd_req = 1'b1; rd_sel = 2'd0;
    tick();
    check("post_rst_read_valid", 32'(choice_valid), 32'h1);
    check("post_rst_read_data", 32'(choice_out), 32'h0);
    rd_req = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
